mux_nway_arb: RTL
=================

# mux_nway_arb

Parametrised N-way, W-bit selector for the datapath, extending the fixed 4-way 32-bit combinational mux with a registered output stage, valid/ready handshaking and a round-robin arbitration mode. It sits between multiple producers (e.g. writeback sources, memory/forwarding ports) and a single consumer, and delivers one selected word per transfer with one cycle of latency.

## Interface
- WIDTH, 32, data width per way (>=1)
- WAYS, 4, number of input ways (>=2, need not be a power of two)
- SEL_W, $clog2(WAYS), derived select/grant width (localparam, not overridable)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WAYS*WIDTH  way i occupies [i*WIDTH +: WIDTH]
- in_valid  input  WAYS  way i has a word offered
- in_ready  output  WAYS  way i's word is taken this cycle (one-hot or zero)
- mode  input  1  0 = fixed select by sel; 1 = round-robin over valid ways
- sel  input  SEL_W  way index used in fixed mode
- data_out  output  WIDTH  registered selected word
- out_valid  output  1  data_out holds an untaken word
- out_ready  input  1  consumer accepts data_out this cycle
- grant  output  SEL_W  way index that produced the current data_out

## Operation
- can_load = !out_valid || out_ready.
- Candidate way:
  - Fixed mode: candidate = sel, valid only if sel < WAYS and in_valid[sel]. sel >= WAYS selects nothing; no in_ready asserted, no transfer.
  - Round-robin mode: search ways starting at (rr_ptr+1) mod WAYS, wrapping, up to WAYS positions; first way with in_valid set is the candidate. No valid way -> no candidate.
- in_ready[i] = can_load && candidate exists && candidate == i. All other bits 0. in_ready is combinational from in_valid, mode, sel, out_valid, out_ready; producers must not make in_valid depend on in_ready.
- Input transfer (in_valid[i] && in_ready[i]) at a clock edge: data_out <= way i data, grant <= i, out_valid <= 1.
- Output transfer (out_valid && out_ready) with no input transfer: out_valid <= 0; data_out and grant hold their last values.
- Simultaneous output and input transfer: new word loaded, out_valid stays 1 (full throughput, one word per cycle).
- out_valid && !out_ready: data_out, grant, out_valid frozen; all in_ready 0 (backpressure).
- rr_ptr updates to the granted index on every input transfer, in either mode; so switching fixed -> round-robin continues fairly from the last way served.
- mode and sel may change any cycle; they affect only the current cycle's candidate, never a word already held.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release): out_valid = 0, data_out = 0, grant = 0, rr_ptr = WAYS-1 (way 0 has first priority after reset). in_ready is 0 while out_valid = 0 only if no candidate; it follows the rules above once rst_n is high.
- Reset mid-operation: held word discarded, no out_valid glitch beyond clearing; rr_ptr restored to WAYS-1.
- Latency: input transfer at edge N -> data_out/out_valid valid after edge N, consumable in cycle N+1.
- Throughput: 1 word/cycle with out_ready held high and a candidate each cycle.
- Round-robin fairness: with all ways continuously valid, grants cycle 0,1,...,WAYS-1,0,...; any valid way waits at most WAYS-1 transfers.
- Wrap-around: rr_ptr = WAYS-1 searches from way 0; for non-power-of-two WAYS, index WAYS is never produced.

## Test plan
- Reset/fixed mode: WAYS=4, WIDTH=32, release rst_n, mode=0, sel=2, in_valid=4'b1111, in_data way k = 32'hA000_000k, out_ready=1 -> in_ready=4'b0100; next cycle data_out=32'hA000_0002, grant=2, out_valid=1; before any edge all outputs 0.
- Backpressure: hold out_ready=0 after one load -> data_out/grant frozen, in_ready=0 for 5 cycles; raise out_ready -> in_ready=4'b0100 same cycle, new word loaded next edge.
- Round-robin: mode=1, in_valid=4'b1111, out_ready=1 from reset -> grants 0,1,2,3,0,1 on consecutive cycles; then in_valid=4'b1010 -> grants alternate 1,3,1,3.
- Mode switch: fixed sel=3 for two transfers, then mode=1 with all valid -> next grant 0 (wrap from rr_ptr=3), then 1.
- Non-power-of-two: WAYS=3, SEL_W=2, mode=0, sel=3 -> in_ready=0, out_valid stays 0; mode=1, in_valid=3'b100 -> grant=2 repeatedly, never 3.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 -> out_valid=0, data_out=0 immediately; after release round-robin restarts at way 0.

Source files
------------

// File: rtl/mux_nway_arb.sv
// N-way, W-bit registered selector with valid/ready handshaking.
// Ways are picked either by an explicit index or round-robin starting after the last way served.
module mux_nway_arb #(
  parameter int WIDTH = 32,
  parameter int WAYS  = 4,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      grant
);

  localparam logic [SEL_W:0]   WAYS_L  = (SEL_W+1)'(WAYS);
  localparam logic [SEL_W-1:0] RR_INIT = SEL_W'(WAYS-1);

  logic             can_load_s;
  logic             cand_valid_s;
  logic             xfer_s;
  logic             hit_s;
  logic [SEL_W-1:0] cand_s;
  logic [SEL_W:0]   idx_s;
  logic [WIDTH-1:0] cand_data_s;
  logic [WAYS-1:0]  in_ready_s;

  logic [WIDTH-1:0] data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] grant_r;
  logic [SEL_W-1:0] rr_ptr_r;

  // Candidate search: explicit index in fixed mode, first valid way after rr_ptr otherwise
  always_comb begin
    cand_valid_s = 1'b0;
    cand_s       = {SEL_W{1'b0}};
    idx_s        = {(SEL_W+1){1'b0}};
    hit_s        = 1'b0;
    if (mode) begin
      for (int k = 1; k <= WAYS; k++) begin
        idx_s = {1'b0, rr_ptr_r} + k[SEL_W:0];
        // Sum never exceeds 2*WAYS-1, so one subtraction is a full modulo
        idx_s = (idx_s >= WAYS_L) ? (idx_s - WAYS_L) : idx_s;
        for (int i = 0; i < WAYS; i++) begin
          hit_s        = !cand_valid_s && in_valid[i] && (idx_s == i[SEL_W:0]);
          cand_s       = hit_s ? i[SEL_W-1:0] : cand_s;
          cand_valid_s = cand_valid_s | hit_s;
        end
      end
    end else begin
      // Only indices below WAYS are compared, so an out-of-range sel matches nothing
      for (int i = 0; i < WAYS; i++) begin
        hit_s        = (sel == i[SEL_W-1:0]) && in_valid[i];
        cand_s       = hit_s ? i[SEL_W-1:0] : cand_s;
        cand_valid_s = cand_valid_s | hit_s;
      end
    end
  end

  // Handshake: accept the candidate only when the output stage is empty or draining
  always_comb begin
    can_load_s  = !out_valid_r || out_ready;
    xfer_s      = can_load_s && cand_valid_s;
    in_ready_s  = {WAYS{1'b0}};
    cand_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      in_ready_s[i] = xfer_s && (cand_s == i[SEL_W-1:0]);
      cand_data_s   = (cand_s == i[SEL_W-1:0]) ? in_data[i*WIDTH +: WIDTH] : cand_data_s;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      grant_r     <= {SEL_W{1'b0}};
      rr_ptr_r    <= RR_INIT;
    end else if (xfer_s) begin
      data_r      <= cand_data_s;
      out_valid_r <= 1'b1;
      grant_r     <= cand_s;
      rr_ptr_r    <= cand_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign data_out  = data_r;
  assign out_valid = out_valid_r;
  assign grant     = grant_r;

endmodule
